// File: rtl/id_decode_stage.sv
// Registered instruction-decode stage: decodes one 32-bit instruction per cycle into control
// fields, with valid/ready handshakes, a per-register load-use scoreboard, flush and illegal flag.
module id_decode_stage #(
  parameter int         REG_AW     = 5,
  parameter int         LOAD_LAT   = 2,
  parameter logic [1:0] NIC_PREFIX = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  output logic [REG_AW-1:0] rd,
  output logic [1:0]        ww,
  output logic [5:0]        op,
  output logic [2:0]        ppp,
  output logic [1:0]        br,
  output logic [15:0]       imm,
  output logic [15:0]       mem_addr,
  output logic              mem_en,
  output logic              store_en,
  output logic              load,
  output logic              wr_en,
  output logic              nic_en,
  output logic              nic_wr,
  output logic [1:0]        nic_addr,
  output logic              illegal
);

  localparam int NREG = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rd;
    logic [1:0]        ww;
    logic [5:0]        op;
    logic [2:0]        ppp;
    logic [1:0]        br;
    logic [15:0]       imm;
    logic [15:0]       mem_addr;
    logic              mem_en;
    logic              store_en;
    logic              load;
    logic              wr_en;
    logic              nic_en;
    logic              nic_wr;
    logic [1:0]        nic_addr;
    logic              illegal;
  } fields_t;

  fields_t    dec, fields_d, fields_q;
  logic       out_valid_d, out_valid_q;
  logic [3:0] cnt_d [NREG];
  logic [3:0] cnt_q [NREG];
  logic       use_a, use_b, hz_a, hz_b, hazard;
  logic       in_fire, out_fire, ld_set;
  logic       nic_win;

  always_comb begin
    dec     = '0;
    use_a   = 1'b0;
    use_b   = 1'b0;
    nic_win = (instr[15:14] == NIC_PREFIX);
    case (instr[31:26])
      6'b101010: begin
        dec.ra    = REG_AW'(instr[20:16]);
        dec.rb    = REG_AW'(instr[15:11]);
        dec.rd    = REG_AW'(instr[25:21]);
        dec.ppp   = instr[10:8];
        dec.ww    = instr[7:6];
        dec.op    = instr[5:0];
        dec.wr_en = 1'b1;
        use_a     = 1'b1;
        use_b     = 1'b1;
      end
      6'b100010, 6'b100011: begin
        dec.ra  = REG_AW'(instr[25:21]);
        dec.br  = {1'b1, instr[26]};
        dec.imm = instr[15:0];
        dec.ppp = instr[10:8];
        use_a   = 1'b1;
      end
      6'b100000: begin
        dec.rd       = REG_AW'(instr[25:21]);
        dec.mem_addr = instr[15:0];
        dec.mem_en   = 1'b1;
        dec.load     = 1'b1;
        dec.wr_en    = 1'b1;
        if (nic_win && !instr[1]) begin
          dec.nic_en   = 1'b1;
          dec.nic_addr = {1'b0, instr[0]};
        end
      end
      6'b100001: begin
        dec.ra       = REG_AW'(instr[25:21]);
        dec.mem_addr = instr[15:0];
        dec.mem_en   = 1'b1;
        dec.store_en = 1'b1;
        use_a        = 1'b1;
        if (nic_win && instr[1]) begin
          dec.nic_en   = 1'b1;
          dec.nic_wr   = 1'b1;
          dec.nic_addr = {1'b1, instr[0]};
        end
      end
      6'b111100: dec.ppp = instr[10:8];
      default:   dec.illegal = 1'b1;
    endcase
  end

  // A held LD has not reached the scoreboard yet, so its rd is checked directly.
  always_comb begin
    hz_a     = (cnt_q[dec.ra] != 4'd0) || (out_valid_q && fields_q.load && fields_q.rd == dec.ra);
    hz_b     = (cnt_q[dec.rb] != 4'd0) || (out_valid_q && fields_q.load && fields_q.rd == dec.rb);
    hazard   = (use_a && hz_a) || (use_b && hz_b);
    in_ready = !reset && !flush && !hazard && (!out_valid_q || out_ready);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready && !flush;
    ld_set   = out_fire && fields_q.load;
  end

  always_comb begin
    fields_d    = fields_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      fields_d    = '0;
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      fields_d    = dec;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ld_set && fields_q.rd == REG_AW'(i))
        cnt_d[i] = 4'(LOAD_LAT);
      else if (cnt_q[i] != 4'd0)
        cnt_d[i] = cnt_q[i] - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fields_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= 4'd0;
    end else begin
      fields_q    <= fields_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ra        = fields_q.ra;
  assign rb        = fields_q.rb;
  assign rd        = fields_q.rd;
  assign ww        = fields_q.ww;
  assign op        = fields_q.op;
  assign ppp       = fields_q.ppp;
  assign br        = fields_q.br;
  assign imm       = fields_q.imm;
  assign mem_addr  = fields_q.mem_addr;
  assign mem_en    = fields_q.mem_en;
  assign store_en  = fields_q.store_en;
  assign load      = fields_q.load;
  assign wr_en     = fields_q.wr_en;
  assign nic_en    = fields_q.nic_en;
  assign nic_wr    = fields_q.nic_wr;
  assign nic_addr  = fields_q.nic_addr;
  assign illegal   = fields_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: hand-computed expectations checked by immediate assertions.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid;
  logic [4:0]  ra, rb, rd;
  logic [1:0]  ww, br, nic_addr;
  logic [5:0]  op;
  logic [2:0]  ppp;
  logic [15:0] imm, mem_addr;
  logic        mem_en, store_en, load, wr_en, nic_en, nic_wr, illegal;

  int vectors = 0;
  int miscompares = 0;
  int stalls;

  always #5 clk = ~clk;

  id_decode_stage #(.REG_AW(5), .LOAD_LAT(2), .NIC_PREFIX(2'b11)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ra(ra), .rb(rb), .rd(rd), .ww(ww), .op(op), .ppp(ppp), .br(br), .imm(imm),
    .mem_addr(mem_addr), .mem_en(mem_en), .store_en(store_en), .load(load), .wr_en(wr_en),
    .nic_en(nic_en), .nic_wr(nic_wr), .nic_addr(nic_addr), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] d, a, b, input logic [5:0] o);
    return {6'b101010, d, a, b, 3'b000, 2'b00, o};
  endfunction

  function automatic logic [31:0] ldw(input logic [4:0] d, input logic [15:0] addr);
    return {6'b100000, d, 5'd0, addr};
  endfunction

  function automatic logic [31:0] sdw(input logic [4:0] a, input logic [15:0] addr);
    return {6'b100001, a, 5'd0, addr};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = 32'd0;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd", rd, 0);
    chk("reset_illegal", illegal, 0);

    // Basic R-type decode
    reset = 1'b0; in_valid = 1'b1; instr = 32'hA822_1882;
    settle();
    chk("rt_in_ready", in_ready, 1);
    step();
    chk("rt_out_valid", out_valid, 1);
    chk("rt_rd", rd, 1);
    chk("rt_ra", ra, 2);
    chk("rt_rb", rb, 3);
    chk("rt_ppp", ppp, 0);
    chk("rt_ww", ww, 2'b10);
    chk("rt_op", op, 6'b000010);
    chk("rt_wr_en", wr_en, 1);
    chk("rt_mem_en", mem_en, 0);
    in_valid = 1'b0;
    step();
    chk("rt_drained", out_valid, 0);

    // LD from NIC window, then dependent SD
    in_valid = 1'b1; instr = ldw(5'd4, 16'hC001);
    step();
    chk("ld_load", load, 1);
    chk("ld_rd", rd, 4);
    chk("ld_mem_addr", mem_addr, 16'hC001);
    chk("ld_nic_en", nic_en, 1);
    chk("ld_nic_wr", nic_wr, 0);
    chk("ld_nic_addr", nic_addr, 2'b01);
    instr = sdw(5'd4, 16'hC003);
    settle();
    stalls = 0;
    for (int i = 0; i < 10 && !in_ready; i++) begin
      stalls++;
      step();
    end
    chk("sd_stall_cycles", stalls, 3);
    step();
    chk("sd_out_valid", out_valid, 1);
    chk("sd_store_en", store_en, 1);
    chk("sd_ra", ra, 4);
    chk("sd_wr_en", wr_en, 0);
    chk("sd_nic_en", nic_en, 1);
    chk("sd_nic_wr", nic_wr, 1);
    chk("sd_nic_addr", nic_addr, 2'b11);
    in_valid = 1'b0;
    step();

    // Backpressure with two instructions queued
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(5'd6, 5'd1, 5'd2, 6'd5);
    step();
    chk("bp_first_rd", rd, 6);
    instr = rtype(5'd7, 5'd8, 5'd9, 6'd9);
    settle();
    chk("bp_in_ready_low", in_ready, 0);
    step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_rd", rd, 6);
    chk("bp_hold_op", op, 5);
    out_ready = 1'b1;
    settle();
    chk("bp_in_ready_high", in_ready, 1);
    step();
    chk("bp_second_rd", rd, 7);
    chk("bp_second_op", op, 9);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 0);

    // Branches
    in_valid = 1'b1; instr = {6'b100010, 5'd3, 5'd0, 16'hABCD};
    step();
    chk("vbnz_br", br, 2'b10);
    chk("vbnz_ra", ra, 3);
    chk("vbnz_imm", imm, 16'hABCD);
    chk("vbnz_ppp", ppp, 3'b011);
    chk("vbnz_mem_en", mem_en, 0);
    instr = {6'b100011, 5'd3, 5'd0, 16'h0100};
    step();
    chk("vbenz_br", br, 2'b11);
    chk("vbenz_ppp", ppp, 3'b001);

    // Illegal opcode then NOP
    instr = 32'hFC00_1234;
    step();
    chk("ill_flag", illegal, 1);
    chk("ill_out_valid", out_valid, 1);
    chk("ill_mem_en", mem_en, 0);
    chk("ill_wr_en", wr_en, 0);
    chk("ill_nic_en", nic_en, 0);
    instr = 32'hF000_0500;
    step();
    chk("nop_illegal", illegal, 0);
    chk("nop_ppp", ppp, 3'b101);
    chk("nop_wr_en", wr_en, 0);
    in_valid = 1'b0;
    step();

    // Flush a held LD; dependent R-type must not stall
    out_ready = 1'b0; in_valid = 1'b1; instr = ldw(5'd5, 16'h0010);
    step();
    chk("fl_ld_held", load, 1);
    chk("fl_ld_nic_en", nic_en, 0);
    in_valid = 1'b0; flush = 1'b1;
    settle();
    chk("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_rd", rd, 0);
    chk("fl_load", load, 0);
    out_ready = 1'b1; in_valid = 1'b1; instr = rtype(5'd9, 5'd5, 5'd5, 6'd1);
    settle();
    chk("fl_no_stall", in_ready, 1);
    step();
    chk("fl_rt_ra", ra, 5);
    in_valid = 1'b0;
    step();

    // Reset during a scoreboard stall
    in_valid = 1'b1; instr = ldw(5'd10, 16'h0020);
    step();
    instr = rtype(5'd11, 5'd10, 5'd0, 6'd3);
    settle();
    chk("rs_stall_held", in_ready, 0);
    step();
    chk("rs_stall_cnt", in_ready, 0);
    reset = 1'b1;
    step();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_rd", rd, 0);
    chk("rs_load", load, 0);
    chk("rs_in_ready", in_ready, 0);
    reset = 1'b0;
    settle();
    chk("rs_ready_after", in_ready, 1);
    step();
    chk("rs_accept_valid", out_valid, 1);
    chk("rs_accept_rd", rd, 11);
    chk("rs_accept_ra", ra, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered, parametrised instruction-decode pipeline stage that sits between instruction fetch and the register-file/execute stage. It decodes the 32-bit ISA (R-type, VBNZ, VBENZ, LD, SD, NOP) into control fields and captures them in an output register with valid/ready handshakes on both sides. It adds three things the pure decoder lacks: a per-register load-use scoreboard that stalls dependent instructions, a branch flush, and illegal-opcode flagging. NIC address detection is parametrised.

## Interface
- REG_AW, 5: register address width (register count = 2^REG_AW); instruction fields are taken from the standard bit positions and truncated to REG_AW.
- LOAD_LAT, 2: cycles after a load issues downstream before its destination may be read (1..15).
- NIC_PREFIX, 2'b11: value of mem_addr[15:14] that selects the NIC window.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instr holds a valid instruction.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  instruction word.
- flush  in  1  discard the held output and refuse input this cycle.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  downstream consumes the fields this cycle.
- ra, rb, rd  out  REG_AW each  source A, source B and destination addresses.
- ww  out  2  write width; op  out  6  ALU op; ppp  out  3  participation field.
- br  out  2  00 none, 10 VBNZ, 11 VBENZ; imm  out  16  branch immediate.
- mem_addr  out  16; mem_en, store_en, load, wr_en  out  1 each.
- nic_en, nic_wr  out  1 each; nic_addr  out  2  NIC register select.
- illegal  out  1  the held instruction had an undefined opcode.

## Operation
- Opcode is instr[31:26]. Field rules:
  - R-type 101010: ra=[20:16], rb=[15:11], rd=[25:21], ppp=[10:8], ww=[7:6], op=[5:0], wr_en=1.
  - VBNZ 100010 / VBENZ 100011: ra=[25:21], br=10/11, imm=[15:0], ppp=[10:8].
  - LD 100000: rd=[25:21], mem_addr=[15:0], mem_en=1, load=1, wr_en=1.
  - SD 100001: ra=[25:21], mem_addr=[15:0], mem_en=1, store_en=1.
  - NOP 111100: all zero except ppp=[10:8].
  - Any other opcode: all fields zero, illegal=1, out_valid still asserted.
- Every field not listed for an opcode is 0, including nic_addr.
- NIC detection uses mem_addr[15:14]==NIC_PREFIX:
  - LD with addr[1]=0: nic_en=1, nic_wr=0, nic_addr={0,addr[0]}.
  - SD with addr[1]=1: nic_en=1, nic_wr=1, nic_addr={1,addr[0]}.
  - Otherwise nic_en=nic_wr=0 and nic_addr=0.
- Source use: R-type reads ra and rb; VBNZ, VBENZ and SD read ra; LD and NOP read nothing.
- Scoreboard: one down-counter per register, 4 bits wide.
  - Loaded with LOAD_LAT when a LD fires downstream (out_valid & out_ready), indexed by rd.
  - Otherwise decrements while nonzero.
  - If a set and a decrement hit the same entry in the same cycle, the set wins.
- A hazard exists when a used source has a nonzero counter, or equals the rd of a LD currently held in the output register.
- in_ready = !reset & !flush & !hazard & (!out_valid | out_ready).
- In fire (in_valid & in_ready): decoded fields are captured and out_valid is set.
- If out fires with no in fire: out_valid clears; the fields keep their values.
- flush: clears out_valid and the whole output register. A flushed LD does not set the scoreboard. Counters already loaded keep counting.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented from edge N onward.
- Full throughput is one instruction per cycle when there are no hazards and out_ready=1.
- Reset (synchronous): out_valid=0, all output fields 0, illegal=0, all counters 0. in_ready=0 while reset is high.
- Reset mid-stall drops the held instruction and clears the scoreboard.
- The hazard check is combinational on instr; it gates in_ready, not out_valid.
- Back-to-back LD then dependent R-type: the R-type stalls for the held cycle plus LOAD_LAT cycles after the LD fires.
- Outputs hold stable while out_valid=1 and out_ready=0.

## Test plan
- Reset, then an R-type instr 0xA8221882 with out_ready=1 -> next cycle rd=1, ra=2, rb=3, ppp=000, ww=10, op=000010, wr_en=1, out_valid=1.
- LD r4 from 0xC001, then SD r4 to 0xC003, LOAD_LAT=2, out_ready=1:
  - LD output: nic_en=1, nic_wr=0, nic_addr=01.
  - SD: in_ready=0 for exactly 3 cycles, then accepted with nic_en=1, nic_wr=1, nic_addr=11.
- Hold out_ready=0 with 2 instructions queued -> first output is stable and in_ready=0; raising out_ready drains both in consecutive cycles.
- Opcode 0x3F -> illegal=1, all enables 0, out_valid=1; the next NOP clears illegal.
- LD r5 held, then flush while out_ready=0 -> out_valid=0 next cycle; a following R-type reading r5 is accepted with no stall.
- Assert reset during a scoreboard stall -> all outputs 0 next cycle; the stalled instruction is accepted in the cycle after reset deasserts.
